r_decode_arb: RTL

//  Packet-granular round-robin arbiter that shares one r_decode datapath between NUM_SRC receive streams.

---
 rtl/r_decode_arb.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/r_decode_arb.sv
// Packet-granular round-robin arbiter sharing one r_decode datapath between NUM_SRC streams.
// Optional stall watchdog enabled by defining R_ARB_WATCHDOG_EN.
module r_decode_arb #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_SRC        = 4,
  parameter int SRC_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SRC*DATA_WIDTH*8-1:0] s_data,
  input  logic [NUM_SRC-1:0]              s_last,
  input  logic [NUM_SRC-1:0]              s_valid,
  output logic [NUM_SRC-1:0]              s_ready,
  output logic [DATA_WIDTH*8-1:0]         m_data,
  output logic                            m_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [SRC_W-1:0]                m_src,
  output logic                            busy,
  output logic                            hdr_last_err,
  output logic                            wd_err,
  output logic [SRC_W-1:0]                wd_src
);

  localparam int BW = DATA_WIDTH * 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [1:0]       beat_cnt_q, beat_cnt_d;
  logic             hdr_err_q, hdr_err_d;
  logic             cur_valid, cur_last, accept;

  // First requester strictly after the previous grant, wrapping modulo NUM_SRC.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                              input logic [SRC_W-1:0]   ptr);
    logic [SRC_W-1:0] g;
    logic             found;
    int               idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        g     = SRC_W'(idx);
        found = 1'b1;
      end
    end
    return g;
  endfunction

  assign cur_valid = s_valid[src_q];
  assign cur_last  = s_last[src_q];
  assign accept    = (state_q == BUSY) && cur_valid && m_ready;
  assign m_data    = s_data[int'(src_q)*BW +: BW];

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    src_d      = src_q;
    beat_cnt_d = beat_cnt_q;
    hdr_err_d  = hdr_err_q;
    m_valid    = 1'b0;
    m_last     = 1'b0;
    s_ready    = '0;
    case (state_q)
      IDLE: begin
        if (|s_valid) begin
          src_d      = rr_pick(s_valid, rr_ptr_q);
          rr_ptr_d   = src_d;
          beat_cnt_d = 2'd0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        m_valid        = cur_valid;
        m_last         = cur_last;
        s_ready[src_q] = m_ready;
        if (accept) begin
          if (cur_last && beat_cnt_q != 2'd0) begin
            state_d    = IDLE;
            beat_cnt_d = 2'd0;
          end else begin
            // last on the header is ignored downstream, so keep the grant and flag it
            if (cur_last) hdr_err_d = 1'b1;
            if (beat_cnt_q != 2'd2) beat_cnt_d = beat_cnt_q + 2'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= SRC_W'(NUM_SRC - 1);
      src_q      <= '0;
      beat_cnt_q <= 2'd0;
      hdr_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      src_q      <= src_d;
      beat_cnt_q <= beat_cnt_d;
      hdr_err_q  <= hdr_err_d;
    end
  end

  assign m_src        = src_q;
  assign busy         = (state_q == BUSY);
  assign hdr_last_err = hdr_err_q;

`ifdef R_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0]  wd_cnt_q;
  logic             wd_err_q;
  logic [SRC_W-1:0] wd_src_q;

  // Counts stalled BUSY cycles; saturates at the limit while the grant is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
      wd_src_q <= '0;
    end else if (state_q != BUSY || accept) begin
      wd_cnt_q <= '0;
    end else if (!cur_valid && wd_cnt_q != WD_W'(TIMEOUT_CYCLES)) begin
      wd_cnt_q <= wd_cnt_q + WD_W'(1);
      if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
        wd_err_q <= 1'b1;
        wd_src_q <= src_q;
      end
    end
  end

  assign wd_err = wd_err_q;
  assign wd_src = wd_src_q;
`else
  assign wd_err = 1'b0;
  assign wd_src = '0;
`endif

endmodule
